filter_pingpong_buffer: RTL and testbench

Parametrised double-buffered filter storage for the convolution datapath.
- A write port streams LANES-wide beats into one bank while the PE side reads single weights from the other bank by index.
- A full/release handshake swaps the banks, so the next filter can load with no read-side stall.

---
 rtl/filter_pingpong_buffer_pkg.sv | 34 +++
 rtl/filter_pingpong_buffer_if.sv | 32 +++
 rtl/filter_pingpong_buffer_bank.sv | 68 ++++++
 rtl/filter_pingpong_buffer.sv | 141 ++++++++++++++
 tb/tb_filter_pingpong_buffer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pingpong_buffer_pkg.sv
// Shared constants, bank-select type and the beat unpack helper for the
// double-buffered filter weight store.
package filter_buf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_LANES  = 4;

    // Widest weight and widest packed beat the generic unpack helper handles.
    localparam int MAX_DATA_W = 32;
    localparam int MAX_BEAT_W = 1024;

    typedef logic bank_sel_t;

    localparam bank_sel_t BANK0 = 1'b0;
    localparam bank_sel_t BANK1 = 1'b1;

    // Extract lane `lane` of a packed beat whose lanes are `data_w` bits wide.
    // The beat is passed zero-extended to MAX_BEAT_W; only the low `data_w`
    // bits of the result are meaningful.
    function automatic logic [MAX_DATA_W-1:0] lane_unpack(
        input logic [MAX_BEAT_W-1:0] beat,
        input int                    lane,
        input int                    data_w
    );
        logic [MAX_BEAT_W-1:0] shifted;
        logic [MAX_BEAT_W-1:0] mask;
        shifted = beat >> (lane * data_w);
        mask    = (MAX_BEAT_W'(1) << data_w) - MAX_BEAT_W'(1);
        shifted = shifted & mask;
        return shifted[MAX_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/filter_pingpong_buffer_if.sv
// Write-stream, read-port and status signals of the filter ping-pong buffer.
// master = the side loading filters and reading weights; slave = the buffer.
interface filter_pingpong_buffer_if #(
    parameter int DATA_W = filter_buf_pkg::DEF_DATA_W,
    parameter int DEPTH  = filter_buf_pkg::DEF_DEPTH,
    parameter int LANES  = filter_buf_pkg::DEF_LANES,
    parameter int ADDR_W = $clog2(DEPTH)
);

    logic                      wr_valid;
    logic                      wr_ready;
    logic [LANES*DATA_W-1:0]   wr_data;
    logic                      wr_last;
    logic                      rd_bank_valid;
    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_index;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_data_valid;
    logic                      rd_release;
    logic                      wrap_err;

    modport master (
        output wr_valid, wr_data, wr_last, rd_en, rd_index, rd_release,
        input  wr_ready, rd_bank_valid, rd_data, rd_data_valid, wrap_err
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_en, rd_index, rd_release,
        output wr_ready, rd_bank_valid, rd_data, rd_data_valid, wrap_err
    );

endinterface

// File: rtl/filter_pingpong_buffer_bank.sv
// One DEPTH x DATA_W weight bank: async clear, LANES-wide write starting at a
// base entry (wrapping modulo DEPTH) and one registered read port.
module filter_bank
    import filter_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wr_base,
    input  logic [LANES*DATA_W-1:0] wr_beat,
    input  logic                    re,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_W-1:0]       rd_q
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] lane_data [LANES];

    // Entry written by lane `lane` of a beat starting at `base`.
    function automatic logic [ADDR_W-1:0] wrap_addr(
        input logic [ADDR_W-1:0] base,
        input int                lane
    );
        int sum;
        sum = int'(base) + lane;
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        return ADDR_W'(sum);
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [MAX_DATA_W-1:0] raw;
        // Upper bits of the generic unpack result are always zero here.
        logic                  unused_raw;
        assign raw          = lane_unpack({{(MAX_BEAT_W-LANES*DATA_W){1'b0}}, wr_beat}, g, DATA_W);
        assign unused_raw   = ^raw;
        assign lane_data[g] = raw[DATA_W-1:0];
    end

    // Clear on reset; otherwise store every lane of an accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < LANES; i++) begin
                mem[wrap_addr(wr_base, i)] <= lane_data[i];
            end
        end
    end

    // Registered read; the output holds when no read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/filter_pingpong_buffer.sv
// Double-buffered filter storage: one bank loads the next filter from a
// LANES-wide beat stream while the PE side reads single weights from the
// other. A full/release handshake swaps the banks.
module filter_pingpong_buffer
    import filter_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    filter_pingpong_buffer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_BEAT_PTR = ADDR_W'(DEPTH - LANES);
    localparam logic [ADDR_W-1:0] LANES_STEP    = ADDR_W'(LANES);

    logic [1:0]        full;
    bank_sel_t         wb;
    bank_sel_t         rb;
    bank_sel_t         rd_sel;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wrap_err_q;
    logic              rd_dv_q;

    logic              accept;
    logic              rd_fire;
    logic              release_fire;
    logic              we0;
    logic              we1;
    logic              re0;
    logic              re1;
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;

    // Handshake status depends only on registered state, so no path exists
    // from the write inputs to any read-side output.
    assign bus.wr_ready      = !full[wb];
    assign bus.rd_bank_valid = full[rb];
    assign bus.wrap_err      = wrap_err_q;
    assign bus.rd_data_valid = rd_dv_q;
    assign bus.rd_data       = (rd_sel == BANK1) ? q1 : q0;

    assign accept       = bus.wr_valid && !full[wb];
    assign rd_fire      = bus.rd_en && full[rb];
    assign release_fire = bus.rd_release && full[rb];

    // A writable bank is never full and a readable bank always is, so the
    // write and read enables never target the same bank in one cycle.
    assign we0 = accept && (wb == BANK0);
    assign we1 = accept && (wb == BANK1);
    assign re0 = rd_fire && (rb == BANK0);
    assign re1 = rd_fire && (rb == BANK1);

    filter_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (we0),
        .wr_base (wr_ptr),
        .wr_beat (bus.wr_data),
        .re      (re0),
        .rd_addr (bus.rd_index),
        .rd_q    (q0)
    );

    filter_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (we1),
        .wr_base (wr_ptr),
        .wr_beat (bus.wr_data),
        .re      (re1),
        .rd_addr (bus.rd_index),
        .rd_q    (q1)
    );

    // Bank ownership: final beat marks the write bank full and moves on;
    // release frees the read bank and moves on. Both may happen together
    // because they always address different banks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 2'b00;
            wb   <= BANK0;
            rb   <= BANK0;
        end else begin
            if (accept && bus.wr_last) begin
                full[wb] <= 1'b1;
                wb       <= ~wb;
            end
            if (release_fire) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
        end
    end

    // Write pointer: restart on each new filter, wrap (and flag it) when a
    // filter overruns the bank without a final beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            wrap_err_q <= 1'b0;
        end else if (accept) begin
            if (bus.wr_last) begin
                wr_ptr <= '0;
            end else if (wr_ptr == LAST_BEAT_PTR) begin
                wr_ptr     <= '0;
                wrap_err_q <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + LANES_STEP;
            end
        end
    end

    // Read tracking: remember which bank produced the last read so the output
    // mux keeps showing it, even after that bank is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dv_q <= 1'b0;
            rd_sel  <= BANK0;
        end else begin
            rd_dv_q <= rd_fire;
            if (rd_fire) begin
                rd_sel <= rb;
            end
        end
    end

endmodule

// File: tb/tb_filter_pingpong_buffer.sv
// Bench for filter_pingpong_buffer: directed scenarios followed by a random
// phase, all checked against a spec-level model of the two banks.
module tb_filter_pingpong_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LANES  = 4;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    filter_pingpong_buffer_if #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)
    ) bus ();

    filter_pingpong_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain bank contents plus ownership flags.
    logic [7:0] m_mem [2][DEPTH];
    bit         m_full [2];
    int         m_wb;
    int         m_rb;
    int         m_ptr;
    bit         m_wrap;
    logic [7:0] m_rd;
    bit         m_rdv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_full[b] = 1'b0;
            for (int e = 0; e < DEPTH; e++) m_mem[b][e] = 8'h00;
        end
        m_wb = 0; m_rb = 0; m_ptr = 0; m_wrap = 1'b0; m_rd = 8'h00; m_rdv = 1'b0;
    endtask

    task automatic check_model(input string ctx);
        chk({ctx, ".wr_ready"},      32'(bus.wr_ready),      32'(!m_full[m_wb]));
        chk({ctx, ".rd_bank_valid"}, 32'(bus.rd_bank_valid), 32'(m_full[m_rb]));
        chk({ctx, ".rd_data_valid"}, 32'(bus.rd_data_valid), 32'(m_rdv));
        chk({ctx, ".rd_data"},       32'(bus.rd_data),       32'(m_rd));
        chk({ctx, ".wrap_err"},      32'(bus.wrap_err),      32'(m_wrap));
    endtask

    // Apply the current inputs to the model, clock the DUT, compare.
    task automatic tick(input string ctx);
        bit acc, fire, rel;
        acc  = bus.wr_valid && !m_full[m_wb];
        fire = bus.rd_en && m_full[m_rb];
        rel  = bus.rd_release && m_full[m_rb];
        if (fire) begin
            m_rd  = m_mem[m_rb][bus.rd_index];
            m_rdv = 1'b1;
        end else begin
            m_rdv = 1'b0;
        end
        if (acc) begin
            for (int i = 0; i < LANES; i++)
                m_mem[m_wb][(m_ptr + i) % DEPTH] = bus.wr_data[i*DATA_W +: DATA_W];
            if (bus.wr_last) begin
                m_full[m_wb] = 1'b1;
                m_wb  = 1 - m_wb;
                m_ptr = 0;
            end else begin
                if (m_ptr == DEPTH - LANES) m_wrap = 1'b1;
                m_ptr = (m_ptr + LANES) % DEPTH;
            end
        end
        if (rel) begin
            m_full[m_rb] = 1'b0;
            m_rb = 1 - m_rb;
        end
        @(posedge clk);
        #1;
        check_model(ctx);
    endtask

    function automatic logic [31:0] seq_beat(input int base);
        logic [31:0] r;
        for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = 8'(base + i);
        return r;
    endfunction

    task automatic put_beat(input logic [31:0] d, input bit last);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_last  = last;
        tick("beat");
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic do_read(input int idx);
        bus.rd_en    = 1'b1;
        bus.rd_index = ADDR_W'(idx);
        tick("read");
        bus.rd_en    = 1'b0;
    endtask

    task automatic do_release();
        bus.rd_release = 1'b1;
        tick("release");
        bus.rd_release = 1'b0;
    endtask

    task automatic fill_seq(input int base);
        for (int b = 0; b < DEPTH / LANES; b++)
            put_beat(seq_beat(base + LANES * b), b == DEPTH / LANES - 1);
    endtask

    logic [31:0] d [6];

    initial begin
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;
        bus.rd_en = 1'b0; bus.rd_index = '0; bus.rd_release = 1'b0;
        model_reset();

        // Power-on reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("por.wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("por.rd_bank_valid", 32'(bus.rd_bank_valid), 32'd0);
        chk("por.rd_data", 32'(bus.rd_data), 32'h00);
        chk("por.rd_data_valid", 32'(bus.rd_data_valid), 32'd0);
        chk("por.wrap_err", 32'(bus.wrap_err), 32'd0);

        // Random full filter into B0, then a partial fill of B1, then reset
        for (int b = 0; b < 4; b++) put_beat($urandom, b == 3);
        chk("pre_rst.rd_bank_valid", 32'(bus.rd_bank_valid), 32'd1);
        put_beat($urandom, 1'b0);
        put_beat($urandom, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst.wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("async_rst.rd_bank_valid", 32'(bus.rd_bank_valid), 32'd0);
        chk("async_rst.rd_data", 32'(bus.rd_data), 32'h00);
        chk("async_rst.rd_data_valid", 32'(bus.rd_data_valid), 32'd0);
        chk("async_rst.wrap_err", 32'(bus.wrap_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_model("after_rst");

        // Fill B0 with 0x00..0x0F and read it back
        fill_seq(8'h00);
        chk("fill0.rd_bank_valid", 32'(bus.rd_bank_valid), 32'd1);
        do_read(5);
        chk("fill0.rd5", 32'(bus.rd_data), 32'h05);
        chk("fill0.rd5_valid", 32'(bus.rd_data_valid), 32'd1);
        do_read(3);
        chk("fill0.rd3", 32'(bus.rd_data), 32'h03);

        // Ping-pong: fill B1 while reading B0 every cycle
        for (int b = 0; b < 4; b++) begin
            chk("pp.wr_ready_during_fill", 32'(bus.wr_ready), 32'd1);
            bus.rd_en    = 1'b1;
            bus.rd_index = ADDR_W'($urandom_range(0, DEPTH - 1));
            put_beat(seq_beat(8'h10 + LANES * b), b == 3);
        end
        bus.rd_en = 1'b0;
        chk("pp.wr_ready_both_full", 32'(bus.wr_ready), 32'd0);

        // Third filter stalls until B0 is released
        bus.wr_valid = 1'b1;
        bus.wr_data  = seq_beat(8'hA0);
        bus.wr_last  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick("stall");
            chk("stall.wr_ready", 32'(bus.wr_ready), 32'd0);
        end
        bus.rd_release = 1'b1;
        tick("stall_release");
        bus.rd_release = 1'b0;
        chk("stall.wr_ready_after_release", 32'(bus.wr_ready), 32'd1);
        tick("short_b0");
        bus.wr_data = seq_beat(8'hA4);
        bus.wr_last = 1'b1;
        tick("short_b1");
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        do_read(0);
        chk("pp.rd0_b1", 32'(bus.rd_data), 32'h10);

        // Short filter landed in B0 over old 0x00..0x0F
        do_release();
        do_read(7);
        chk("short.rd7", 32'(bus.rd_data), 32'hA7);
        do_read(8);
        chk("short.rd8_old", 32'(bus.rd_data), 32'h08);

        // Wrap: six beats into B1, wr_last only on the sixth
        for (int k = 0; k < 6; k++) d[k] = $urandom;
        for (int k = 0; k < 5; k++) begin
            put_beat(d[k], 1'b0);
            if (k == 2) chk("wrap.err_before", 32'(bus.wrap_err), 32'd0);
            if (k == 3) chk("wrap.err_after4", 32'(bus.wrap_err), 32'd1);
        end
        put_beat(d[5], 1'b1);
        do_release();
        for (int j = 0; j < LANES; j++) begin
            do_read(j);
            chk("wrap.fifth_beat", 32'(bus.rd_data), 32'(d[4][j*DATA_W +: DATA_W]));
        end
        do_read(7);
        chk("wrap.sixth_beat", 32'(bus.rd_data), 32'(d[5][3*DATA_W +: DATA_W]));
        do_read(8);
        chk("wrap.third_beat", 32'(bus.rd_data), 32'(d[2][7:0]));

        // Same-cycle read and release of B0 holding 0x00..0x0F
        fill_seq(8'h00);
        do_release();
        bus.rd_en      = 1'b1;
        bus.rd_index   = ADDR_W'(2);
        bus.rd_release = 1'b1;
        tick("rd_rel");
        bus.rd_en      = 1'b0;
        bus.rd_release = 1'b0;
        chk("rd_rel.data", 32'(bus.rd_data), 32'h02);
        chk("rd_rel.valid", 32'(bus.rd_data_valid), 32'd1);
        chk("rd_rel.bank_valid", 32'(bus.rd_bank_valid), 32'd0);

        // Release with nothing full is ignored
        do_release();
        chk("idle_rel.bank_valid", 32'(bus.rd_bank_valid), 32'd0);
        chk("idle_rel.wr_ready", 32'(bus.wr_ready), 32'd1);
        put_beat(seq_beat(8'h55), 1'b1);
        chk("idle_rel.next_bank_valid", 32'(bus.rd_bank_valid), 32'd1);
        do_read(1);
        chk("idle_rel.rd1", 32'(bus.rd_data), 32'h56);
        do_release();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            bus.wr_valid   = 1'($urandom_range(0, 1));
            bus.wr_data    = $urandom;
            bus.wr_last    = ($urandom_range(0, 3) == 0);
            bus.rd_en      = 1'($urandom_range(0, 1));
            bus.rd_index   = ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.rd_release = ($urandom_range(0, 5) == 0);
            tick("rand");
        end
        bus.wr_valid = 1'b0; bus.rd_en = 1'b0; bus.rd_release = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
